lsu_mem_master: RTL
===================

# lsu_mem_master

Load/store initiator that sits between the single-cycle core's memory stage and the word-addressed data RAM. It accepts one RISC-V load or store request per handshake and translates it into RAM accesses. Loads are extracted and sign- or zero-extended. Sub-word stores are done by read-modify-write, and misaligned or illegal requests are reported with an error response instead of touching memory.

## Interface
- N_ADDR, 10, byte-address width; matches the data RAM address width.
- M_DATA, 32, data width; fixed at 32 for RV32 access sizes.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  core presents a request.
- req_ready  out  1  block accepts the request.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 access size and sign.
- req_addr  in  N_ADDR  byte address.
- req_wdata  in  M_DATA  store data, right-aligned.
- resp_valid  out  1  response available.
- resp_ready  in  1  core consumes the response.
- resp_data  out  M_DATA  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned access or illegal funct3.
- mem_we  out  1  RAM write enable.
- mem_addr  out  N_ADDR  RAM byte address; bits [1:0] are always 0.
- mem_wdata  out  M_DATA  RAM write word.
- mem_rdata  in  M_DATA  RAM read word, combinational from mem_addr.

## Operation
- Legal loads:
  - funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores:
  - funct3 000 SB, 001 SH, 010 SW.
- Any other funct3 is illegal, and so is a store with funct3[2]=1.
- Alignment rules:
  - Halfword access requires addr[0]=0.
  - Word access requires addr[1:0]=00.
  - Byte access is always aligned.
- Byte lane is addr[1:0]; halfword lane is addr[1]. Lane 0 is bits [7:0] (little-endian).
- On accept, the block registers store, funct3, addr and wdata.
  - mem_addr = {addr_q[N_ADDR-1:2], 2'b00} in every non-IDLE state.
  - mem_addr is 0 in IDLE.
- State machine, states IDLE, ACCESS, WRITE, RESP:
  - IDLE: req_ready=1. On req_valid, the request is accepted. An error request goes to RESP with resp_err=1. Any other request goes to ACCESS.
  - ACCESS, load: capture the extended lane of mem_rdata into resp_data, then go to RESP.
  - ACCESS, SW: mem_we=1 with mem_wdata=wdata_q, then go to RESP.
  - ACCESS, SB/SH: capture the merged word (mem_rdata with the target lane replaced by the low byte or halfword of wdata_q), then go to WRITE.
  - WRITE: mem_we=1 with mem_wdata=the merged word, then go to RESP.
  - RESP: resp_valid=1. When resp_ready=1, go to IDLE.
- resp_data and resp_err are registered and hold stable while resp_valid=1.
- mem_we is asserted only in ACCESS (SW) and WRITE. mem_wdata is 0 whenever mem_we=0.
- Error requests never assert mem_we and never change RAM contents.

## Timing
- Request accepted at edge T (req_valid & req_ready sampled high).
- resp_valid rises after the edge at:
  - load: T+2
  - SW: T+2; the RAM write happens at edge T+2
  - SB/SH: T+3; the write happens at edge T+3
  - error: T+1
- resp_ready held high gives one request per 3 cycles (loads, SW) or 4 cycles (SB/SH).
- resp_ready=0 in RESP: the block stays in RESP and all outputs hold.
- req_ready=0 outside IDLE; req_valid there is ignored.
- Reset asserted (rst=0):
  - The state machine goes to IDLE immediately, asynchronously.
  - These outputs are 0: req_ready, resp_valid, resp_data, resp_err, mem_we, mem_addr, mem_wdata.
  - req_ready rises on the first edge after release.
- Reset mid-operation aborts the access. A pending RMW write is dropped and no partial write occurs.

## Structure
- Package lsu_pkg holds:
  - the funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state encoding (IDLE, ACCESS, WRITE, RESP).
- Sub-module lsu_align is combinational and computes:
  - load lane extraction and sign/zero extension from mem_rdata, addr[1:0] and funct3;
  - store lane merge from mem_rdata, wdata, addr[1:0] and funct3;
  - error detection.
- The top level holds the FSM, the request registers and the response registers.
- The bench instantiates the block with the data RAM (word-addressed by addr[N_ADDR-1:2]).

## Test plan
- Preload word 0x20 = 0x8899AABB, then LW 0x20: resp_data=0x8899AABB, resp_err=0, resp_valid at T+2.
- LB 0x23 gives resp_data=0xFFFFFF88. LBU 0x23 gives 0x00000088. LH 0x22 gives 0xFFFF8899. LHU 0x20 gives 0x0000AABB.
- SB 0x21 with wdata 0x12345677 on word 0x8899AABB: RAM word becomes 0x889977BB, one mem_we pulse at T+3, resp_valid at T+3.
- Misaligned requests each give resp_err=1 and resp_data=0 at T+1, with mem_we never asserted: SW 0x22, LH 0x21, and funct3 011 load.
- resp_ready held 0 for 5 cycles in RESP: resp_valid and resp_data stay stable and a new req_valid is not accepted.
- rst=0 asserted during WRITE of an SH: mem_we is 0 immediately, the RAM word is unchanged, and after release req_ready=1 and the next LW returns the original data.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store initiator: RISC-V funct3 access sizes and FSM states.
// Pure declarations; no timing or flow-control behaviour lives here.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Lane extract/extend for loads, lane merge for sub-word stores, and legality check.
// Purely combinational, zero latency; no flow control.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        i_store,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  input  logic [15:0] i_wdata_lo,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merge_data,
  output logic        o_err
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_load_data = i_rdata;
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load_data = {24'h0, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load_data = {16'h0, w_half};
      default: o_load_data = i_rdata;
    endcase
  end

  always_comb begin
    o_merge_data = i_rdata;
    if (i_funct3 == F3_B) begin
      case (i_addr_lo)
        2'd0: o_merge_data[7:0]   = i_wdata_lo[7:0];
        2'd1: o_merge_data[15:8]  = i_wdata_lo[7:0];
        2'd2: o_merge_data[23:16] = i_wdata_lo[7:0];
        2'd3: o_merge_data[31:24] = i_wdata_lo[7:0];
        default: o_merge_data = i_rdata;
      endcase
    end else if (i_funct3 == F3_H) begin
      if (i_addr_lo[1]) o_merge_data[31:16] = i_wdata_lo;
      else              o_merge_data[15:0]  = i_wdata_lo;
    end
  end

  // Unsigned variants exist only for loads, so a store with funct3[2]=1 is illegal.
  always_comb begin
    case (i_funct3)
      F3_B:    o_err = 1'b0;
      F3_BU:   o_err = i_store;
      F3_H:    o_err = i_addr_lo[0];
      F3_HU:   o_err = i_store | i_addr_lo[0];
      F3_W:    o_err = (i_addr_lo != 2'b00);
      default: o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: one request per handshake; response 1 (error), 2 (load/SW) or 3 (SB/SH) edges after accept.
// req_ready only in IDLE; RESP holds every output until resp_ready.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int N_ADDR = 10,
  parameter int M_DATA = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [N_ADDR-1:0] req_addr,
  input  logic [M_DATA-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [M_DATA-1:0] resp_data,
  output logic              resp_err,
  output logic              mem_we,
  output logic [N_ADDR-1:0] mem_addr,
  output logic [M_DATA-1:0] mem_wdata,
  input  logic [M_DATA-1:0] mem_rdata
);

  lsu_state_e        r_state;
  lsu_state_e        w_next;
  logic              r_live;
  logic              r_store;
  logic [2:0]        r_funct3;
  logic [N_ADDR-1:0] r_addr;
  logic [M_DATA-1:0] r_wdata;
  logic [M_DATA-1:0] r_merge;
  logic [M_DATA-1:0] r_resp_data;
  logic              r_resp_err;

  logic              w_idle;
  logic              w_accept;
  logic              w_sw;
  logic              w_sel_store;
  logic [2:0]        w_sel_funct3;
  logic [1:0]        w_sel_addr_lo;
  logic [M_DATA-1:0] w_load_data;
  logic [M_DATA-1:0] w_merge_data;
  logic              w_err;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = w_idle & r_live & req_valid;
  assign w_sw     = r_store & (r_funct3 == F3_W);

  // The checker looks at the live request while idle and at the captured one afterwards.
  assign w_sel_store   = w_idle ? req_store     : r_store;
  assign w_sel_funct3  = w_idle ? req_funct3    : r_funct3;
  assign w_sel_addr_lo = w_idle ? req_addr[1:0] : r_addr[1:0];

  lsu_align u_align (
    .i_store      (w_sel_store),
    .i_funct3     (w_sel_funct3),
    .i_addr_lo    (w_sel_addr_lo),
    .i_rdata      (mem_rdata),
    .i_wdata_lo   (r_wdata[15:0]),
    .o_load_data  (w_load_data),
    .o_merge_data (w_merge_data),
    .o_err        (w_err)
  );

  // Holds req_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_live <= 1'b0;
    else      r_live <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_err ? RESP : ACCESS;
      ACCESS:  w_next = (r_store && !w_sw) ? WRITE : RESP;
      WRITE:   w_next = RESP;
      RESP:    if (resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_store     <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_merge     <= '0;
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
    end else if (w_accept) begin
      r_store     <= req_store;
      r_funct3    <= req_funct3;
      r_addr      <= req_addr;
      r_wdata     <= req_wdata;
      r_resp_data <= '0;
      r_resp_err  <= w_err;
    end else if (r_state == ACCESS) begin
      if (r_store) r_merge     <= w_merge_data;
      else         r_resp_data <= w_load_data;
    end
  end

  always_comb begin
    req_ready  = w_idle & r_live;
    resp_valid = (r_state == RESP);
    resp_data  = r_resp_data;
    resp_err   = r_resp_err;
    mem_addr   = w_idle ? '0 : {r_addr[N_ADDR-1:2], 2'b00};
    mem_we     = 1'b0;
    mem_wdata  = '0;
    if (r_state == ACCESS && w_sw) begin
      mem_we    = 1'b1;
      mem_wdata = r_wdata;
    end else if (r_state == WRITE) begin
      mem_we    = 1'b1;
      mem_wdata = r_merge;
    end
  end

endmodule
